sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 10 +
 rtl/fifo_mem.sv | 39 +++
 rtl/sync_fifo.sv | 71 +++++++
 tb/tb_sync_fifo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared word-width definitions for the multiplier datapath and the FIFO that
// buffers products between the multiplier and the accumulator.
`timescale 1ns/1ps
package sync_fifo_pkg;

  localparam int mult_bits       = 32;
  localparam int matrix_val_bits = 16;
  localparam int vec_val_bits    = 16;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM with a registered read port; the output register lives
// here so the array and dout together can map onto a block RAM.
`timescale 1ns/1ps
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = mult_bits,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata = '0;

  // NOTE: the array has no reset; clearing it would block RAM inference and
  // the pointers already guarantee stale words are never read.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst)     r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered (non-fall-through) read port. Pointers carry one
// extra lap bit so full and empty are distinguishable with equal low bits.
`timescale 1ns/1ps
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = mult_bits,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic [WIDTH-1:0] dout,
  input  logic             rd_en,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr = '0;
  logic [AW:0] r_rptr = '0;
  logic        w_wr_accept;
  logic        w_rd_accept;
  logic [AW:0] w_wptr_nxt;
  logic [AW:0] w_rptr_nxt;

  // Flags come from registered pointers only, so a request never gates itself.
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_wr_accept = wr_en & ~full;
  assign w_rd_accept = rd_en & ~empty;
  assign w_wptr_nxt  = r_wptr + {{AW{1'b0}}, w_wr_accept};
  assign w_rptr_nxt  = r_rptr + {{AW{1'b0}}, w_rd_accept};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_wr_accept),
    .waddr (r_wptr[AW-1:0]),
    .wdata (din),
    .re    (w_rd_accept),
    .raddr (r_rptr[AW-1:0]),
    .rdata (dout)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(full && empty)) else $error("full and empty both set");
      if (wr_en && full)  assert (w_wptr_nxt == r_wptr) else $error("wptr moved on rejected write");
      if (rd_en && empty) assert (w_rptr_nxt == r_rptr) else $error("rptr moved on rejected read");
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a reference queue predicts accepted traffic, and
// a separate monitor compares dout one cycle after each predicted read.
`timescale 1ns/1ps
module tb_sync_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] din   = '0;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q   [$];
  logic [WIDTH-1:0] model_dout = '0;
  logic             exp_valid  = 1'b0;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .wr_en (wr_en),
    .full  (full),
    .dout  (dout),
    .rd_en (rd_en),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
  endtask

  // One clock of stimulus; the reference decides acceptance from pre-edge occupancy.
  task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r);
    logic w_ok;
    logic r_ok;
    wr_en = w;
    rd_en = r;
    din   = d;
    r_ok  = r && (model_q.size() > 0);
    w_ok  = w && (model_q.size() < DEPTH);
    exp_valid = r_ok;
    if (r_ok) begin
      model_dout = model_q.pop_front();
      exp_q.push_back(model_dout);
    end
    if (w_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    check_flags("cyc");
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    wr_en     = 1'b1;
    rd_en     = 1'b1;
    din       = 32'hBAD;
    exp_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_q.delete();
    model_dout = '0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_dout",  dout,       32'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (model_q.size() > 0 && guard < 4 * DEPTH) begin
      cycle(1'b0, '0, 1'b1);
      guard++;
    end
    cycle(1'b0, '0, 1'b0);
  endtask

  task automatic run_tests();
    logic             w;
    logic             r;
    logic             acc;
    logic [WIDTH-1:0] next_word;
    int               written;
    int               iter;

    do_reset(2);

    // Fill 1..16, then overflow, then read+write while full.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    cycle(1'b1, 32'hDEAD, 1'b0);
    cycle(1'b1, 32'hBEEF, 1'b1);
    check("full_rw_not_full", 32'(full), 32'd0);
    drain();
    check("drain_last", dout, 32'd16);

    // Underflow: dout must hold 16.
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("underflow_hold", dout, 32'd16);

    // Read+write while empty: write only, dout untouched.
    cycle(1'b1, 32'h77, 1'b1);
    check("empty_rw_dout", dout, 32'd16);
    check("empty_rw_empty", 32'(empty), 32'd0);
    drain();

    // Half occupancy streaming for 20 cycles.
    for (int i = 0; i < DEPTH / 2; i++) cycle(1'b1, 32'h100 + WIDTH'(i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h200 + WIDTH'(i), 1'b1);
    check("half_occ", 32'(model_q.size()), 32'(DEPTH / 2));
    drain();

    // Wrap-around: 100 words with random gating.
    next_word = 32'h1000;
    written   = 0;
    iter      = 0;
    while (written < 100 && iter < 2000) begin
      w   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      acc = w && (model_q.size() < DEPTH);
      cycle(w, next_word, r);
      if (acc) begin
        next_word++;
        written++;
      end
      iter++;
    end
    check("wrap_written", 32'(written), 32'd100);
    drain();

    // Mid-operation reset discards stored words.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h300 + WIDTH'(i), 1'b0);
    do_reset(1);
    cycle(1'b1, 32'h55, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("mid_rst_dout", dout, 32'h55);

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      begin : monitor
        logic pend;
        forever begin
          @(posedge clk);
          pend = exp_valid;
          @(negedge clk);
          if (pend) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL dout_unexpected: got %0h expected no read", dout);
            end else begin
              check("dout", dout, exp_q.pop_front());
            end
          end
        end
      end
      begin : stimulus
        run_tests();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
      end
    join
  end

endmodule
